// File: rtl/ntt_butterfly_unit_pkg.sv
// Shared constants and mode encoding for the NTT butterfly pipeline.
package ntt_butterfly_unit_pkg;

  // Pipeline depth of the integer multiplier and of the modular reduction.
  localparam int INTMUL_DELAY = 1;
  localparam int MODRED_DELAY = 1;

  // Operation selected for each coefficient pair.
  typedef enum logic [1:0] {
    BFLY_MODE_CT      = 2'b00,
    BFLY_MODE_GS      = 2'b01,
    BFLY_MODE_MUL     = 2'b10,
    BFLY_MODE_GS_HALF = 2'b11
  } bfly_mode_e;

  // Both GS flavours feed (A-B) into the multiplier and add A+B up front.
  function automatic logic isGsMode(input bfly_mode_e m);
    return (m == BFLY_MODE_GS) || (m == BFLY_MODE_GS_HALF);
  endfunction

endpackage

// File: rtl/ntt_butterfly_unit_modmul_pipe.sv
// Pipelined modular multiplier: full-width product, then reduction by a
// per-operation modulus that travels down the pipe with its product.
module modmul_pipe
  import ntt_butterfly_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] p_o
);

  logic [2*WIDTH-1:0] prod_q  [INTMUL_DELAY];
  logic [WIDTH-1:0]   qPipe_q [INTMUL_DELAY];
  logic [WIDTH-1:0]   rem_q   [MODRED_DELAY];
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   rem_d;

  // Widen operands before multiplying and reduce the last product stage.
  always_comb begin
    prod_d = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    rem_d  = WIDTH'(prod_q[INTMUL_DELAY-1] % {{WIDTH{1'b0}}, qPipe_q[INTMUL_DELAY-1]});
  end

  // Advance the product, its modulus and the reduced result on each enabled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < INTMUL_DELAY; i++) begin
        prod_q[i]  <= '0;
        qPipe_q[i] <= '0;
      end
      for (int i = 0; i < MODRED_DELAY; i++) begin
        rem_q[i] <= '0;
      end
    end else if (en_i) begin
      prod_q[0]  <= prod_d;
      qPipe_q[0] <= q_i;
      for (int i = 1; i < INTMUL_DELAY; i++) begin
        prod_q[i]  <= prod_q[i-1];
        qPipe_q[i] <= qPipe_q[i-1];
      end
      rem_q[0] <= rem_d;
      for (int i = 1; i < MODRED_DELAY; i++) begin
        rem_q[i] <= rem_q[i-1];
      end
    end
  end

  assign p_o = rem_q[MODRED_DELAY-1];

endmodule

// File: rtl/ntt_butterfly_unit.sv
// Fully pipelined CT/GS/MUL/GS_HALF butterfly over an odd modulus q.
// Stage 0 registers operands (GS pre-add/sub), the multiplier pipe follows,
// and the final stage does the post-add/sub/halve into the output registers.
module ntt_butterfly_unit
  import ntt_butterfly_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] modulus,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MUL_LAT = INTMUL_DELAY + MODRED_DELAY;

  // x+y mod q for x,y < q: one conditional subtract in WIDTH+1 bits.
  function automatic logic [WIDTH-1:0] modAdd(input logic [WIDTH-1:0] x, y, q);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[WIDTH-1:0];
  endfunction

  // x-y mod q for x,y < q: the top bit flags a borrow, fixed by adding q.
  function automatic logic [WIDTH-1:0] modSub(input logic [WIDTH-1:0] x, y, q);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, q};
    return d[WIDTH-1:0];
  endfunction

  // x/2 mod q for odd q: odd x becomes even after adding q.
  function automatic logic [WIDTH-1:0] modHalve(input logic [WIDTH-1:0] x, q);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  bfly_mode_e       modeIn;
  logic [WIDTH-1:0] aSide_d, mulOp_d;

  logic             s0Valid_q;
  bfly_mode_e       s0Mode_q;
  logic [WIDTH-1:0] s0ASide_q, s0MulOp_q, s0W_q, s0Q_q;
  logic [TAG_W-1:0] s0Tag_q;

  logic             dlValid_q [MUL_LAT];
  bfly_mode_e       dlMode_q  [MUL_LAT];
  logic [WIDTH-1:0] dlASide_q [MUL_LAT];
  logic [WIDTH-1:0] dlQ_q     [MUL_LAT];
  logic [TAG_W-1:0] dlTag_q   [MUL_LAT];

  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] aOut_d, bOut_d;

  logic             outValid_q;
  logic [WIDTH-1:0] aOut_q, bOut_q;
  logic [TAG_W-1:0] outTag_q;

  // GS modes pre-combine A and B; the multiplier sees (A-B) for GS, else B.
  always_comb begin
    modeIn = bfly_mode_e'(mode);
    if (isGsMode(modeIn)) begin
      aSide_d = modAdd(A, B, modulus);
      mulOp_d = modSub(A, B, modulus);
    end else begin
      aSide_d = A;
      mulOp_d = B;
    end
  end

  // Stage 0 captures the operation; delay lines keep its sideband aligned with the product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0Valid_q <= 1'b0;
      s0Mode_q  <= BFLY_MODE_CT;
      s0ASide_q <= '0;
      s0MulOp_q <= '0;
      s0W_q     <= '0;
      s0Q_q     <= '0;
      s0Tag_q   <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        dlValid_q[i] <= 1'b0;
        dlMode_q[i]  <= BFLY_MODE_CT;
        dlASide_q[i] <= '0;
        dlQ_q[i]     <= '0;
        dlTag_q[i]   <= '0;
      end
    end else if (en) begin
      s0Valid_q <= in_valid;
      s0Mode_q  <= modeIn;
      s0ASide_q <= aSide_d;
      s0MulOp_q <= mulOp_d;
      s0W_q     <= W;
      s0Q_q     <= modulus;
      s0Tag_q   <= in_tag;
      dlValid_q[0] <= s0Valid_q;
      dlMode_q[0]  <= s0Mode_q;
      dlASide_q[0] <= s0ASide_q;
      dlQ_q[0]     <= s0Q_q;
      dlTag_q[0]   <= s0Tag_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        dlValid_q[i] <= dlValid_q[i-1];
        dlMode_q[i]  <= dlMode_q[i-1];
        dlASide_q[i] <= dlASide_q[i-1];
        dlQ_q[i]     <= dlQ_q[i-1];
        dlTag_q[i]   <= dlTag_q[i-1];
      end
    end
  end

  modmul_pipe #(
    .WIDTH (WIDTH)
  ) u_modmul (
    .clk   (clk),
    .reset (reset),
    .en_i  (en),
    .a_i   (s0MulOp_q),
    .b_i   (s0W_q),
    .q_i   (s0Q_q),
    .p_o   (prod)
  );

  // Post-processing per mode once the reduced product arrives.
  always_comb begin
    aOut_d = '0;
    bOut_d = '0;
    case (dlMode_q[MUL_LAT-1])
      BFLY_MODE_CT: begin
        aOut_d = modAdd(dlASide_q[MUL_LAT-1], prod, dlQ_q[MUL_LAT-1]);
        bOut_d = modSub(dlASide_q[MUL_LAT-1], prod, dlQ_q[MUL_LAT-1]);
      end
      BFLY_MODE_GS: begin
        aOut_d = dlASide_q[MUL_LAT-1];
        bOut_d = prod;
      end
      BFLY_MODE_MUL: begin
        aOut_d = prod;
        bOut_d = '0;
      end
      BFLY_MODE_GS_HALF: begin
        aOut_d = modHalve(dlASide_q[MUL_LAT-1], dlQ_q[MUL_LAT-1]);
        bOut_d = modHalve(prod, dlQ_q[MUL_LAT-1]);
      end
    endcase
  end

  // Register the results so outputs stay stable while the pipe is frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outValid_q <= 1'b0;
      aOut_q     <= '0;
      bOut_q     <= '0;
      outTag_q   <= '0;
    end else if (en) begin
      outValid_q <= dlValid_q[MUL_LAT-1];
      aOut_q     <= aOut_d;
      bOut_q     <= bOut_d;
      outTag_q   <= dlTag_q[MUL_LAT-1];
    end
  end

  assign out_valid = outValid_q;
  assign A_out     = aOut_q;
  assign B_out     = bOut_q;
  assign out_tag   = outTag_q;

endmodule
